// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM reader and the read sequencer:
// default address/data widths and the sequencer FSM state encoding.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_W = 13;
  localparam int unsigned SDRAM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } seq_state_e;

endpackage

// File: rtl/sdram_rd_fifo.sv
// First-word-fall-through FIFO for words returned by the SDRAM reader.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset (empties the FIFO)
//   push, push_data   write one word (ignored when full)
//   pop               remove the head word (ignored when empty)
//   head              current head word, valid whenever empty=0
//   empty, full       occupancy flags
//   count             number of stored words (0..DEPTH)
module sdram_rd_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W:0]    count_q;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/sdram_read_sequencer.sv
// Command stage ahead of sdram_reader: walks base_addr..base_addr+length-1,
// issuing one single-word read at a time, and streams the returned words out
// through a FWFT FIFO on a valid/ready interface.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   start, base_addr,
//   length                 job request (start ignored while busy)
//   busy, done, error      job status; error is a sticky read-timeout flag
//   rd_address, rd_enable,
//   rd_data, rd_done       handshake to the SDRAM reader
//   out_data, out_valid,
//   out_ready              downstream word stream
module sdram_read_sequencer
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W     = SDRAM_ADDR_W,
  parameter int unsigned DATA_W     = SDRAM_DATA_W,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] rd_address,
  output logic              rd_enable,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_e        state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [TMO_W-1:0]  tmo_q;
  logic [TMO_W-1:0]  tmo_inc;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic              rd_enable_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              issue_ok;

  assign tmo_inc   = tmo_q + TMO_W'(1);
  assign issue_ok  = (fifo_count < CNT_W'(FIFO_DEPTH));
  // Only one read is outstanding and issue waits for space, so the full
  // guard never drops a word in practice.
  assign fifo_push = (state_q == ST_WAIT) && rd_done && !fifo_full;
  assign fifo_pop  = !fifo_empty && out_ready;

  // busy stays high through the done cycle and drops on the following edge,
  // which is also why a start coinciding with done is still ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      tmo_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rd_enable_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      rd_enable_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start && !busy_q) begin
            cur_addr_q  <= base_addr;
            remaining_q <= length;
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= (length == '0) ? ST_FINISH : ST_ISSUE;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (issue_ok) begin
            rd_enable_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmo_q <= tmo_inc;
          // rd_done takes priority over a timeout expiring in the same cycle.
          if (rd_done) begin
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - ADDR_W'(1);
            state_q     <= (remaining_q == ADDR_W'(1)) ? ST_FINISH : ST_ISSUE;
          end else if (tmo_inc == TMO_W'(TIMEOUT)) begin
            error_q <= 1'b1;
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sdram_rd_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (rd_data),
    .pop       (fifo_pop),
    .head      (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign rd_address = cur_addr_q;
  assign rd_enable  = rd_enable_q;
  assign out_valid  = !fifo_empty;

endmodule

// File: tb/tb_sdram_read_sequencer.sv
module tb_sdram_read_sequencer;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DATA_W = 32;
  localparam logic [31:0] XMASK  = 32'hA5A5A5A5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic              busy, done, error;
  logic [ADDR_W-1:0] rd_address;
  logic              rd_enable;
  logic [DATA_W-1:0] rd_data;
  logic              rd_done;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic              reader_on;
  logic [ADDR_W-1:0] en_addr[$];
  logic [DATA_W-1:0] out_q[$];
  int unsigned       done_cnt = 0;
  int unsigned       e0, o0, d0;

  always #5 clk = ~clk;

  sdram_read_sequencer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (8),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rd_address (rd_address),
    .rd_enable  (rd_enable),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observes the interfaces on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rd_enable) en_addr.push_back(rd_address);
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (done) done_cnt++;
  end

  // Reader model: answers each rd_enable with addr^XMASK, 3 cycles later.
  initial begin : reader
    logic [ADDR_W-1:0] raddr;
    rd_done = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_enable && reader_on) begin
        raddr = rd_address;
        repeat (2) @(posedge clk);
        #1;
        rd_done = 1'b1;
        rd_data = {{(DATA_W-ADDR_W){1'b0}}, raddr} ^ XMASK;
        @(posedge clk); #1;
        rd_done = 1'b0;
      end
    end
  end

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    @(posedge clk); #1;
    e0 = en_addr.size();
    o0 = out_q.size();
    d0 = done_cnt;
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int unsigned budget, output int unsigned n);
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin : main
    int unsigned n;
    int unsigned seen;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    out_ready = 1'b1;
    reader_on = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy",  {31'd0, busy},      32'd0);
    check_eq("rst_done",  {31'd0, done},      32'd0);
    check_eq("rst_error", {31'd0, error},     32'd0);
    check_eq("rst_rden",  {31'd0, rd_enable}, 32'd0);
    check_eq("rst_oval",  {31'd0, out_valid}, 32'd0);
    check_eq("rst_addr",  {19'd0, rd_address}, 32'd0);
    check_eq("rst_odata", out_data,           32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic run
    start_job(13'h0010, 13'd4);
    @(negedge clk);
    check_eq("basic_busy1", {31'd0, busy},      32'd1);
    check_eq("basic_rden1", {31'd0, rd_enable}, 32'd0);
    @(negedge clk);
    check_eq("basic_rden2", {31'd0, rd_enable}, 32'd1);
    check_eq("basic_addr2", {19'd0, rd_address}, 32'h0010);
    wait_done("basic", 100, n);
    check_eq("basic_busy_at_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("basic_busy_after", {31'd0, busy}, 32'd0);
    check_eq("basic_done_after", {31'd0, done}, 32'd0);
    settle();
    check_eq("basic_nread", en_addr.size() - e0, 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq("basic_addr", {19'd0, en_addr[e0 + i]}, 32'h0010 + i);
    check_eq("basic_nout", out_q.size() - o0, 32'd4);
    check_eq("basic_w0", out_q[o0 + 0], 32'hA5A5A5B5);
    check_eq("basic_w1", out_q[o0 + 1], 32'hA5A5A5B4);
    check_eq("basic_w2", out_q[o0 + 2], 32'hA5A5A5B7);
    check_eq("basic_w3", out_q[o0 + 3], 32'hA5A5A5B6);
    check_eq("basic_ndone", done_cnt - d0, 32'd1);
    check_eq("basic_error", {31'd0, error}, 32'd0);

    // Backpressure
    out_ready = 1'b0;
    start_job(13'h0100, 13'd12);
    repeat (80) @(posedge clk);
    #1;
    check_eq("bp_nread_held", en_addr.size() - e0, 32'd8);
    check_eq("bp_busy",  {31'd0, busy},      32'd1);
    check_eq("bp_rden",  {31'd0, rd_enable}, 32'd0);
    check_eq("bp_oval",  {31'd0, out_valid}, 32'd1);
    check_eq("bp_head",  out_data,           32'hA5A5A4A5);
    out_ready = 1'b1;
    wait_done("bp", 200, n);
    repeat (12) @(posedge clk);
    #1;
    check_eq("bp_nread", en_addr.size() - e0, 32'd12);
    check_eq("bp_nout",  out_q.size() - o0,   32'd12);
    for (int i = 0; i < 12; i++)
      check_eq("bp_word", out_q[o0 + i], (32'h0100 + i) ^ XMASK);
    check_eq("bp_drained", {31'd0, out_valid}, 32'd0);

    // Address wrap
    start_job(13'h1FFE, 13'd4);
    wait_done("wrap", 100, n);
    settle();
    check_eq("wrap_nread", en_addr.size() - e0, 32'd4);
    check_eq("wrap_a0", {19'd0, en_addr[e0 + 0]}, 32'h1FFE);
    check_eq("wrap_a1", {19'd0, en_addr[e0 + 1]}, 32'h1FFF);
    check_eq("wrap_a2", {19'd0, en_addr[e0 + 2]}, 32'h0000);
    check_eq("wrap_a3", {19'd0, en_addr[e0 + 3]}, 32'h0001);

    // Empty job
    start_job(13'h0033, 13'd0);
    @(negedge clk);
    check_eq("empty_done1", {31'd0, done}, 32'd0);
    check_eq("empty_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_eq("empty_done2", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_eq("empty_done3", {31'd0, done}, 32'd0);
    check_eq("empty_busy3", {31'd0, busy}, 32'd0);
    settle();
    check_eq("empty_nread", en_addr.size() - e0, 32'd0);

    // Start while busy is ignored
    start_job(13'h0020, 13'd5);
    repeat (6) @(posedge clk);
    #1;
    base_addr = 13'h0300;
    length    = 13'd1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("ign", 100, n);
    settle();
    check_eq("ign_nread", en_addr.size() - e0, 32'd5);
    check_eq("ign_first", {19'd0, en_addr[e0]},     32'h0020);
    check_eq("ign_last",  {19'd0, en_addr[e0 + 4]}, 32'h0024);
    check_eq("ign_ndone", done_cnt - d0, 32'd1);

    // Timeout: rd_enable after E1, 255 WAIT edges, done visible at 258th negedge
    reader_on = 1'b0;
    start_job(13'h0040, 13'd2);
    wait_done("tmo", 400, n);
    check_eq("tmo_latency", n, 32'd258);
    check_eq("tmo_error",   {31'd0, error}, 32'd1);
    @(negedge clk);
    check_eq("tmo_busy_after",  {31'd0, busy},  32'd0);
    check_eq("tmo_error_stick", {31'd0, error}, 32'd1);
    settle();
    check_eq("tmo_nread", en_addr.size() - e0, 32'd1);
    reader_on = 1'b1;
    start_job(13'h0060, 13'd1);
    @(negedge clk);
    check_eq("tmo_err_clr", {31'd0, error}, 32'd0);
    wait_done("tmo_next", 100, n);
    check_eq("tmo_next_err", {31'd0, error}, 32'd0);
    settle();

    // Reset during WAIT of the second word
    out_ready = 1'b0;
    start_job(13'h0050, 13'd6);
    seen = 0;
    n = 0;
    while (seen < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (rd_enable) seen++;
    end
    check_eq("mid_second_read", seen, 32'd2);
    check_eq("mid_oval_pre", {31'd0, out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_busy",  {31'd0, busy},       32'd0);
    check_eq("mid_rden",  {31'd0, rd_enable},  32'd0);
    check_eq("mid_oval",  {31'd0, out_valid},  32'd0);
    check_eq("mid_addr",  {19'd0, rd_address}, 32'd0);
    check_eq("mid_odata", out_data,            32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    e0 = en_addr.size();
    repeat (6) @(negedge clk);
    check_eq("stray_oval", {31'd0, out_valid}, 32'd0);
    check_eq("stray_busy", {31'd0, busy},      32'd0);
    settle();
    check_eq("stray_nread", en_addr.size() - e0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sdram_read_sequencer.md
Name: sdram_read_sequencer

Overview:
Upstream command stage for sdram_reader. Walks a contiguous range of SDRAM word addresses and issues one single-word read at a time over the reader's address/read_enable/read_done handshake. Each returned 32-bit word goes into a small first-word-fall-through FIFO, presented downstream on a valid/ready stream (e.g. to a display or UART consumer). Flow control holds issue while the FIFO cannot accept a word; a per-read timeout flags a stalled reader.

Parameters:
ADDR_W, 13, SDRAM word address width; matches the reader address port
DATA_W, 32, data word width
FIFO_DEPTH, 8, output FIFO entries; power of 2, minimum 2
TIMEOUT, 255, cycles to wait for rd_done before aborting the job; minimum 1

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job start; ignored while busy=1
base_addr  in  ADDR_W  first word address; sampled on accepted start
length  in  ADDR_W  number of words to read; sampled on accepted start; 0 = empty job
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at job end (normal or aborted)
error  out  1  sticky timeout flag; cleared on next accepted start
rd_address  out  ADDR_W  to reader address
rd_enable  out  1  to reader read_enable; one-cycle pulse per word
rd_data  in  DATA_W  from reader data_out
rd_done  in  1  from reader read_done; rd_data valid in that cycle
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO not empty
out_ready  in  1  downstream accepts out_data when out_valid and out_ready are both high

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy, done, error, rd_enable, out_valid = 0; rd_address, out_data = 0; FIFO emptied; all counters 0. Reset mid-job abandons the job; a late rd_done after reset release is ignored in IDLE.
- Registers: cur_addr (ADDR_W), remaining (ADDR_W), tmo (8 bits, sized to hold TIMEOUT), fifo count (log2(FIFO_DEPTH)+1 bits).
- FSM states: IDLE, ISSUE, WAIT, FINISH.
- IDLE: when start=1, latch cur_addr=base_addr and remaining=length, clear error, set busy. Go to FINISH if length==0, else go to ISSUE.
- ISSUE: if FIFO count < FIFO_DEPTH, drive rd_enable=1 for exactly this cycle, clear tmo, and go to WAIT. Otherwise hold with rd_enable=0. Only one read is outstanding at a time, so a push never hits a full FIFO.
- rd_address = cur_addr, registered. It is stable from ISSUE through WAIT.
- WAIT: tmo increments each cycle.
  - On rd_done=1: push rd_data into the FIFO, set cur_addr = cur_addr+1 (mod 2^ADDR_W, wraps 0x1FFF -> 0x0000), and decrement remaining. Go to FINISH if remaining was 1, else go to ISSUE.
  - If rd_done=1 and tmo reaches TIMEOUT in the same cycle, rd_done wins.
  - If tmo reaches TIMEOUT without rd_done: set error=1, drop the word, and go to FINISH.
- FINISH: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. FIFO contents are kept and continue to drain after done.
- Latencies: start to first rd_enable is 2 cycles when the FIFO has space. rd_done to the next rd_enable is 2 cycles (WAIT->ISSUE->pulse). A pushed word appears on out_valid/out_data in the cycle after rd_done.
- FIFO: first-word-fall-through, so out_data = head entry. Pop when out_valid and out_ready are both high. Simultaneous push and pop in one cycle is legal; count stays unchanged and ordering is preserved. A pop when empty is a no-op. Read and write pointers wrap modulo FIFO_DEPTH.
- start while busy: ignored, with no effect on the job or on error.

Decomposition:
- Shared package sdram_pkg: FSM state encoding (IDLE/ISSUE/WAIT/FINISH), SDRAM_ADDR_W=13, SDRAM_DATA_W=32. The reader and the sequencer both use these.
- One sub-module: sdram_rd_fifo (parameters DATA_W and DEPTH; ports push/push_data/pop/head/empty/full/count). The sequencer holds only the FSM, counters and timeout.

Test Plan:
- Basic run: base_addr=0x0010, length=4, reader model returns data=addr^0xA5A5A5A5 with 3-cycle latency, out_ready=1 -> rd_address 0x0010..0x0013 in order, 4 rd_enable pulses, out_data 0xA5A5A5B5..0xA5A5A5B6 sequence matches, one done pulse, error=0.
- Backpressure: length=12, FIFO_DEPTH=8, out_ready=0 -> exactly 8 rd_enable pulses, then rd_enable stays 0 and busy=1. Raise out_ready -> remaining 4 reads issue, 12 words come out in order, then done.
- Address wrap: base_addr=0x1FFE, length=4 -> rd_address sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Empty and ignored starts: length=0 -> done pulse 2 cycles after start, no rd_enable. A start pulse mid-job (length=5) -> still exactly 5 reads.
- Timeout: reader never asserts rd_done, TIMEOUT=255 -> error=1 and done pulse after 255 WAIT cycles, busy=0. Next start with a good reader -> error clears.
- Reset mid-job: assert reset_n=0 during WAIT of word 2 of 6 -> all outputs 0 and FIFO empty immediately. After release, a stray rd_done produces no push and out_valid stays 0.
